// File: rtl/gfx_pkg.sv
// Shared constants for the rectangle-fill engine: frame defaults, VRAM address
// width and the fill FSM state encoding.
package gfx_pkg;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int VRAM_AW   = 17;

  typedef logic [1:0]         state_t;
  typedef logic [VRAM_AW-1:0] vaddr_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;
endpackage

// File: rtl/gfx_addr_gen.sv
// Address generator: latches the command geometry, clips it to the frame and
// walks col/row plus the row_base accumulator one accepted pixel at a time.
module gfx_addr_gen
  import gfx_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       setup_i,
  input  logic       advance_i,
  input  logic [8:0] x0_i,
  input  logic [7:0] y0_i,
  input  logic [8:0] width_i,
  input  logic [7:0] height_i,
  output logic       empty_o,
  output logic       last_o,
  output vaddr_t     first_addr_o,
  output vaddr_t     next_addr_o
);
  localparam logic [9:0] H_LIM    = 10'(H_RES);
  localparam logic [9:0] V_LIM    = 10'(V_RES);
  localparam vaddr_t     H_STEP   = vaddr_t'(H_RES);
  localparam vaddr_t     ADDR_ONE = vaddr_t'(1);

  logic [8:0] x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [7:0] y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic [9:0] x_end_q, x_end_d, y_end_q, y_end_d;
  vaddr_t     row_base_q, row_base_d;
  logic [9:0] x_sum, y_sum, x_end_c, y_end_c;
  logic       row_end;

  always_comb begin
    x_sum   = {1'b0, x0_q} + {1'b0, w_q};
    y_sum   = {2'b0, y0_q} + {2'b0, h_q};
    x_end_c = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end_c = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty_o = (w_q == 9'd0) || (h_q == 8'd0) ||
              ({1'b0, x0_q} >= H_LIM) || ({2'b0, y0_q} >= V_LIM);
    row_end = ({1'b0, col_q} == (x_end_q - 10'd1));
    last_o  = row_end && ({2'b0, row_q} == (y_end_q - 10'd1));
    first_addr_o = row_base_q + vaddr_t'(x0_q);
    next_addr_o  = row_end ? (row_base_q + H_STEP + vaddr_t'(x0_q))
                           : (row_base_q + vaddr_t'(col_q) + ADDR_ONE);
  end

  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    if (load_i) begin
      x0_d  = x0_i;
      y0_d  = y0_i;
      w_d   = width_i;
      h_d   = height_i;
      col_d = x0_i;
      row_d = y0_i;
      // Constant-coefficient product taken at command latch; FILL only ever adds H_RES.
      row_base_d = vaddr_t'(y0_i) * H_STEP;
    end else if (setup_i) begin
      x_end_d = x_end_c;
      y_end_d = y_end_c;
    end else if (advance_i) begin
      if (row_end) begin
        col_d      = x0_q;
        row_d      = row_q + 8'd1;
        row_base_d = row_base_q + H_STEP;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
    end else begin
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
    end
  end
endmodule

// File: rtl/gfx_rect_fill.sv
// Rectangle fill engine: writes one colour into a clipped rectangle of linear
// video memory, one pixel per accepted write, row-major.
module gfx_rect_fill
  import gfx_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [8:0]         x0,
  input  logic [7:0]         y0,
  input  logic [8:0]         width,
  input  logic [7:0]         height,
  input  logic [7:0]         color,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [VRAM_AW-1:0] mem_addr,
  output logic [7:0]         mem_din,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [1:0]         state_dbg
);
  // Memory handshake: mem_we is valid, mem_ready is ready. A write transfers in
  // any cycle where both are high; while mem_we is high and mem_ready low, the
  // address, data and mem_we are held unchanged.
  state_t state_q, state_d;
  logic   busy_q, busy_d, done_q, done_d, we_q, we_d;
  vaddr_t addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic   load, setup, advance, empty, last;
  vaddr_t first_addr, next_addr;

  gfx_addr_gen #(.H_RES(H_RES), .V_RES(V_RES)) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (load),
    .setup_i      (setup),
    .advance_i    (advance),
    .x0_i         (x0),
    .y0_i         (y0),
    .width_i      (width),
    .height_i     (height),
    .empty_o      (empty),
    .last_o       (last),
    .first_addr_o (first_addr),
    .next_addr_o  (next_addr)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    load    = 1'b0;
    setup   = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          din_d   = color;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        setup = 1'b1;
        if (abort || empty) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FILL;
          we_d    = 1'b1;
          addr_d  = first_addr;
        end
      end
      ST_FILL: begin
        advance = mem_ready;
        // An abort still lets this cycle's write land if it is accepted.
        if ((mem_ready && last) || abort) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          we_d    = 1'b0;
        end else if (mem_ready) begin
          addr_d = next_addr;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_gfx_rect_fill.sv
// Self-checking bench for gfx_rect_fill: directed and random fills compared
// against a pixel-list model of the clipped rectangle.
module tb_gfx_rect_fill;
  import gfx_pkg::*;

  localparam int H_RES = 320;
  localparam int V_RES = 240;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, mem_ready;
  logic [8:0]  x0, width;
  logic [7:0]  y0, height, color;
  logic        busy, done, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic [1:0]  state_dbg;

  logic [16:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  gfx_rect_fill #(.H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .color     (color),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // rmode: 0 ready always high, 1 ready every other cycle, 2 random ready.
  // abort_k: 0 none, -1 abort in SETUP, k>0 abort during the k-th accepted write.
  // junk: keep start high with random fields for the whole command, incl. FINISH.
  task automatic run_fill(input int x0v, input int y0v, input int wv, input int hv,
                          input int cv, input int rmode, input int abort_k, input bit junk);
    int xe, ye, n_full, n_exp, budget, t, acc, done_t, first_we_t, last_acc_t, busy_bad;
    logic        stall_prev;
    logic [16:0] addr_prev;
    logic [7:0]  din_prev;
    exp_q.delete();
    if (wv > 0 && hv > 0 && x0v < H_RES && y0v < V_RES) begin
      xe = (x0v + wv > H_RES) ? H_RES : x0v + wv;
      ye = (y0v + hv > V_RES) ? V_RES : y0v + hv;
      for (int r = y0v; r < ye; r++)
        for (int c = x0v; c < xe; c++)
          exp_q.push_back(17'(r * H_RES + c));
    end
    n_full = exp_q.size();
    if (abort_k == -1) exp_q.delete();
    else if (abort_k > 0) while (exp_q.size() > abort_k) void'(exp_q.pop_back());
    n_exp  = exp_q.size();
    budget = 4 * n_full + 50;

    x0 = 9'(x0v); y0 = 8'(y0v); width = 9'(wv); height = 8'(hv); color = 8'(cv);
    start = 1'b1; abort = 1'b0; mem_ready = 1'b1;
    t = 0; acc = 0; done_t = -1; first_we_t = -1; last_acc_t = -1; busy_bad = 0;
    stall_prev = 1'b0; addr_prev = '0; din_prev = '0;
    while (t < budget && done_t < 0) begin
      @(posedge clk); #1;
      t++;
      abort = 1'b0;
      if (junk) begin
        start  = 1'b1;
        x0     = 9'($urandom_range(0, 511));
        y0     = 8'($urandom_range(0, 255));
        width  = 9'($urandom_range(0, 511));
        height = 8'($urandom_range(0, 255));
        color  = 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_t = t;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      if (mem_we && first_we_t < 0) first_we_t = t;
      if (stall_prev)
        check("stall_hold", {mem_we, mem_addr, mem_din}, {1'b1, addr_prev, din_prev});
      case (rmode)
        1:       mem_ready = ((t % 2) == 0);
        2:       mem_ready = 1'($urandom_range(0, 1));
        default: mem_ready = 1'b1;
      endcase
      if (abort_k == -1 && t == 1) abort = 1'b1;
      if (abort_k > 0 && mem_we && mem_ready && acc == abort_k - 1) abort = 1'b1;
      if (mem_we && mem_ready) begin
        check("write", {mem_addr, mem_din},
              {((acc < n_exp) ? exp_q[acc] : 17'h1ffff), 8'(cv)});
        acc++;
        last_acc_t = t;
      end
      stall_prev = mem_we && !mem_ready;
      addr_prev  = mem_addr;
      din_prev   = mem_din;
    end
    abort = 1'b0;
    check("done_seen", (done_t >= 0), 1);
    check("write_count", acc, n_exp);
    check("done_after_last", done_t, (n_exp > 0) ? last_acc_t + 1 : 2);
    if (rmode == 0) check("done_latency", done_t, 2 + n_exp);
    if (n_exp > 0) check("first_we", first_we_t, 2);
    check("busy_window", busy_bad, 0);
    @(posedge clk); #1;
    start = 1'b0;
    mem_ready = 1'b1;
    check("idle_after_done", {busy, done, mem_we}, 3'b000);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b1;
    x0 = '0; y0 = '0; width = '0; height = '0; color = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, mem_we, mem_addr, mem_din, state_dbg},
          {3'b000, 17'd0, 8'd0, ST_IDLE});
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    run_fill(10, 5, 3, 2, 8'hAB, 0, 0, 1'b0);     // addrs 1610..1612, 1930..1932
    run_fill(318, 239, 5, 4, 8'h3C, 0, 0, 1'b0);  // clipped to 76798, 76799
    run_fill(50, 50, 0, 7, 8'h11, 0, 0, 1'b0);    // zero width
    run_fill(320, 10, 8, 2, 8'h22, 0, 0, 1'b0);   // off the right edge
    run_fill(5, 5, 4, 0, 8'h33, 0, 0, 1'b0);      // zero height
    run_fill(5, 240, 4, 3, 8'h44, 0, 0, 1'b0);    // below the frame
    run_fill(20, 30, 10, 1, 8'h55, 0, 3, 1'b1);   // abort on 3rd write, start spam
    run_fill(20, 30, 10, 4, 8'h66, 0, -1, 1'b0);  // abort in SETUP
    run_fill(0, 0, 320, 240, 8'h77, 1, 1500, 1'b0);
    run_fill(0, 230, 320, 20, 8'h88, 1, 0, 1'b0); // bottom band, ends at 76799

    for (int i = 0; i < 20; i++)
      run_fill($urandom_range(0, 330), $urandom_range(0, 245), $urandom_range(0, 40),
               $urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 2),
               0, 1'($urandom_range(0, 1)));

    // Reset in the middle of a fill.
    x0 = 9'd0; y0 = 8'd0; width = 9'd100; height = 8'd3; color = 8'h5A;
    start = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midfill_active", {busy, mem_we}, 2'b11);
    #2 reset_n = 1'b0;
    #1 check("reset_async", {busy, done, mem_we}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", {busy, done, mem_we, mem_addr}, 20'd0);
    end
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_reset_idle", {busy, done, mem_we}, 3'b000);
    end
    run_fill(7, 100, 12, 3, 8'hC3, 2, 0, 1'b0);
    run_fill(300, 200, 40, 50, 8'hE1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
